// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO-mapped FIFO controller: register offsets,
// CTRL/STATUS bit positions, the STATUS word layout and the read-op decode.
package mmio_fifo_pkg;

    // Register offsets from BASE_ADDR, in MMIO dword units
    localparam logic [15:0] OFS_DATA_IN  = 16'd0;
    localparam logic [15:0] OFS_DATA_OUT = 16'd2;
    localparam logic [15:0] OFS_STATUS   = 16'd4;
    localparam logic [15:0] OFS_CTRL     = 16'd6;
    localparam logic [15:0] OFS_PEEK     = 16'd8;

    // CTRL register bits
    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    // STATUS register bit positions
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_COUNT_MSB = 9;
    localparam int STAT_UNF_BIT   = 16;
    localparam int STAT_OVF_BIT   = 17;

    // STATUS word as seen by the host, MSB first
    typedef struct packed {
        logic [45:0] rsvd_hi;
        logic        ovf;
        logic        unf;
        logic [5:0]  rsvd_mid;
        logic [7:0]  count;
        logic        full;
        logic        empty;
    } t_fifo_status;

    // Which read-side operation the current MMIO read selects
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_POP    = 2'd1,
        RD_STATUS = 2'd2,
        RD_PEEK   = 2'd3
    } t_rd_op;

    // Assemble the 64-bit STATUS word from the live flags
    function automatic logic [63:0] pack_status(
        input logic       ovf,
        input logic       unf,
        input logic [7:0] count,
        input logic       full,
        input logic       empty
    );
        t_fifo_status s;
        s          = '0;
        s.ovf      = ovf;
        s.unf      = unf;
        s.count    = count;
        s.full     = full;
        s.empty    = empty;
        return s;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. All pointer control lives in the controller.
module fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed word into the slot addressed by the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO controller for a host-visible FIFO: decodes writes into push/ctrl and
// reads into pop/status/peek, keeps occupancy and sticky error flags, and
// returns read responses exactly one cycle after the request.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          WIDTH     = 64,
    parameter logic [15:0] BASE_ADDR = 16'h0020
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [15:0]                wr_addr,
    input  logic [63:0]                wr_data,
    input  logic                       rd_valid,
    input  logic [15:0]                rd_addr,
    input  logic [8:0]                 rd_tid,
    output logic                       rsp_valid,
    output logic [8:0]                 rsp_tid,
    output logic [63:0]                rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       fifo_full,
    output logic                       fifo_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             unf;
    logic [WIDTH-1:0] head;

    logic [15:0]      wr_ofs;
    logic [15:0]      rd_ofs;
    t_rd_op           rd_op;
    logic             push;
    logic             ctrl_wr;
    logic             flush;
    logic             clear;
    logic             pop;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_set;
    logic             unf_set;
    logic             empty;
    logic             full;
    logic [63:0]      rd_data;

    assign wr_ofs = wr_addr - BASE_ADDR;
    assign rd_ofs = rd_addr - BASE_ADDR;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Write-side decode; writes to read-only or unmapped offsets fall through
    assign push    = wr_valid && (wr_ofs == OFS_DATA_IN);
    assign ctrl_wr = wr_valid && (wr_ofs == OFS_CTRL);
    assign flush   = ctrl_wr && wr_data[CTRL_FLUSH_BIT];
    assign clear   = ctrl_wr && wr_data[CTRL_CLEAR_BIT];

    // Read-side decode; reads of write-only or unmapped offsets produce no response
    always_comb begin
        rd_op = RD_NONE;
        if (rd_valid) begin
            case (rd_ofs)
                OFS_DATA_OUT: rd_op = RD_POP;
                OFS_STATUS:   rd_op = RD_STATUS;
                OFS_PEEK:     rd_op = RD_PEEK;
                default:      rd_op = RD_NONE;
            endcase
        end
    end

    assign pop = (rd_op == RD_POP);

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted when paired with a successful pop. No bypass on empty.
    assign pop_ok  = pop && !empty;
    assign unf_set = pop && empty;
    assign push_ok = push && (!full || pop_ok);
    assign ovf_set = push && full && !pop_ok;

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_data[WIDTH-1:0]),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Response data is built from pre-edge state, so STATUS never sees a same-cycle write
    always_comb begin
        rd_data = '0;
        case (rd_op)
            RD_POP, RD_PEEK: rd_data = empty ? 64'd0 : 64'(head);
            RD_STATUS:       rd_data = pack_status(ovf, unf, 8'(count), full, empty);
            default:         rd_data = '0;
        endcase
    end

    // Pointer and occupancy update; flush overrides any same-cycle pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clear) begin
                ovf <= 1'b0;
            end
            if (unf_set) begin
                unf <= 1'b1;
            end else if (clear) begin
                unf <= 1'b0;
            end
        end
    end

    // Registered one-cycle read response; reset cancels anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (rd_op != RD_NONE);
            if (rd_op != RD_NONE) begin
                rsp_tid  <= rd_tid;
                rsp_data <= rd_data;
            end
        end
    end

    assign fifo_count = count;
    assign fifo_full  = full;
    assign fifo_empty = empty;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed bench for mmio_fifo_ctrl. Stimulus pushes expected read responses
// into a scoreboard queue; a negedge monitor pops and compares them whenever
// rsp_valid is seen, and flags unexpected or missing responses.
module tb_mmio_fifo_ctrl;

    localparam logic [15:0] A_DIN  = 16'h0020;
    localparam logic [15:0] A_DOUT = 16'h0022;
    localparam logic [15:0] A_STAT = 16'h0024;
    localparam logic [15:0] A_CTRL = 16'h0026;
    localparam logic [15:0] A_PEEK = 16'h0028;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [8:0]  rd_tid;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks;
    int         n_fails;
    int         cyc;
    logic [8:0] next_tid;

    mmio_fifo_ctrl #(
        .DEPTH     (8),
        .WIDTH     (64),
        .BASE_ADDR (16'h0020)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_addr    (rd_addr),
        .rd_tid     (rd_tid),
        .rsp_valid  (rsp_valid),
        .rsp_tid    (rsp_tid),
        .rsp_data   (rsp_data),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    // Free-running clock and cycle counter used to pin response latency
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of MMIO traffic, queuing the expected read response if any
    task automatic applyStimulus(input bit do_wr, input logic [15:0] waddr, input logic [63:0] wdata,
                                 input bit do_rd, input logic [15:0] raddr,
                                 input bit exp_rsp, input logic [63:0] exp_data);
        exp_t e;
        wr_valid = do_wr;
        wr_addr  = waddr;
        wr_data  = wdata;
        rd_valid = do_rd;
        rd_addr  = raddr;
        rd_tid   = next_tid;
        if (do_rd && exp_rsp) begin
            e.tid  = next_tid;
            e.data = exp_data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        next_tid = next_tid + 9'd1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        applyStimulus(1'b1, a, d, 1'b0, 16'h0, 1'b0, 64'h0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [63:0] exp);
        applyStimulus(1'b0, 16'h0, 64'h0, 1'b1, a, 1'b1, exp);
    endtask

    task automatic rd_none(input logic [15:0] a);
        applyStimulus(1'b0, 16'h0, 64'h0, 1'b1, a, 1'b0, 64'h0);
    endtask

    task automatic wr_rd(input logic [15:0] wa, input logic [63:0] d, input logic [15:0] ra, input logic [63:0] exp);
        applyStimulus(1'b1, wa, d, 1'b1, ra, 1'b1, exp);
    endtask

    // Monitor: pop and compare on every response, flag strays and overdue ones
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_rsp: got tid 0x%0h data 0x%0h, expected no response",
                         rsp_tid, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rsp_tid", 64'(rsp_tid), 64'(mon_e.tid));
                checkOutput("rsp_data", rsp_data, mon_e.data);
                checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            n_fails++;
            $display("[TB] FAIL missing_rsp: got no response, expected tid 0x%0h data 0x%0h",
                     mon_e.tid, mon_e.data);
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus
    initial begin
        n_checks = 0;
        n_fails  = 0;
        next_tid = 9'h1A5;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        rd_tid   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_rsp_data", rsp_data, 64'h0);
        checkOutput("reset_count", 64'(fifo_count), 64'h0);
        checkOutput("reset_empty", 64'(fifo_empty), 64'h1);
        rd(A_STAT, 64'h1);

        $display("[TB] fill, overflow, drain");
        for (int i = 0; i < 8; i++) wr(A_DIN, 64'h11 + 64'(i));
        rd(A_STAT, 64'h22);
        checkOutput("full_flag", 64'(fifo_full), 64'h1);
        wr(A_DIN, 64'h99);
        rd(A_STAT, 64'h20022);
        for (int i = 0; i < 8; i++) rd(A_DOUT, 64'h11 + 64'(i));
        rd(A_STAT, 64'h20001);

        $display("[TB] underflow and clear");
        rd(A_DOUT, 64'h0);
        rd(A_STAT, 64'h30001);
        wr(A_CTRL, 64'h2);
        rd(A_STAT, 64'h1);

        $display("[TB] push+pop on full");
        for (int i = 0; i < 8; i++) wr(A_DIN, 64'h11 + 64'(i));
        wr_rd(A_DIN, 64'hAA, A_DOUT, 64'h11);
        rd(A_STAT, 64'h22);
        for (int i = 1; i < 8; i++) rd(A_DOUT, 64'h11 + 64'(i));
        rd(A_DOUT, 64'hAA);
        rd(A_STAT, 64'h1);

        $display("[TB] push+pop on empty");
        wr_rd(A_DIN, 64'h77, A_DOUT, 64'h0);
        rd(A_STAT, 64'h10004);
        rd(A_DOUT, 64'h77);
        wr(A_CTRL, 64'h2);
        rd(A_STAT, 64'h1);

        $display("[TB] flush with same-cycle pop");
        wr(A_DIN, 64'h41);
        wr(A_DIN, 64'h42);
        wr_rd(A_CTRL, 64'h1, A_DOUT, 64'h41);
        rd(A_STAT, 64'h1);

        $display("[TB] set beats clear");
        wr_rd(A_CTRL, 64'h2, A_DOUT, 64'h0);
        rd(A_STAT, 64'h10001);
        wr(A_CTRL, 64'h2);

        $display("[TB] ignored accesses");
        rd_none(A_DIN);
        rd_none(A_CTRL);
        rd_none(16'h002A);
        rd_none(16'h001E);
        wr(A_STAT, 64'hFFFF);
        wr(A_DOUT, 64'h5);
        wr(16'h002A, 64'h5);
        rd(A_STAT, 64'h1);

        $display("[TB] peek, flush, wrap");
        wr(A_DIN, 64'h31);
        wr(A_DIN, 64'h32);
        wr(A_DIN, 64'h33);
        rd(A_PEEK, 64'h31);
        rd(A_PEEK, 64'h31);
        rd(A_STAT, 64'hC);
        wr(A_CTRL, 64'h1);
        rd(A_STAT, 64'h1);
        rd(A_PEEK, 64'h0);
        wr(A_DIN, 64'h5);
        rd(A_DOUT, 64'h5);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 5; i++) wr(A_DIN, 64'h51 + 64'(i));
        checkOutput("count_before_rst", 64'(fifo_count), 64'h5);
        rst      = 1'b1;
        rd_valid = 1'b1;
        rd_addr  = A_STAT;
        rd_tid   = 9'h033;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rd_valid = 1'b0;
        checkOutput("rst_cancels_rsp", 64'(rsp_valid), 64'h0);
        checkOutput("count_after_rst", 64'(fifo_count), 64'h0);
        rd(A_STAT, 64'h1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending_rsp", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
